sa_result_drain: RTL and testbench

//  Collects partial-sum results leaving the bottom row of the systolic MAC array (res_out chain), one word per column.

---
 rtl/sa_result_drain.sv | 139 +++++++++++++
 tb/tb_sa_result_drain.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Deskews the bottom-row result chain of the systolic array, packs each aligned row
// and queues it in a FIFO for a valid/ready consumer. Overflow drops rows and is sticky.
module sa_result_drain #(
  parameter int WORD_SIZE  = 8,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   num_vec,
  input  logic [7:0]                    lat,
  input  logic [COLS*2*WORD_SIZE-1:0]   res_in,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*2*WORD_SIZE-1:0]   out_data,
  output logic                          overflow
);

  localparam int IW = 2 * WORD_SIZE;
  localparam int VW = COLS * IW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  // WAIT leaves on edge E0+L+COLS-2; the counter reads k-1 on edge E0+k.
  localparam logic [15:0] WAIT_OFS = 16'(COLS - 3);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]    m_lat;
  logic [7:0]     l_lat;
  logic [15:0]    wait_cnt;
  logic [15:0]    row_cnt;
  logic [15:0]    wait_tgt;
  logic [VW-1:0]  aligned;

  logic [VW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, push, pop, wr_en;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_direct
      assign aligned[c*IW +: IW] = res_in[c*IW +: IW];
    end else begin : g_dly
      localparam int D = COLS - 1 - c;
      logic [IW-1:0] pipe [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= res_in[c*IW +: IW];
          for (int unsigned i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign aligned[c*IW +: IW] = pipe[D-1];
    end
  end

  assign wait_tgt  = {8'd0, l_lat} + WAIT_OFS;
  assign out_valid = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = out_valid & out_ready;
  assign push      = (state == CAPTURE);
  assign wr_en     = push & (~full | pop);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    unique case (state)
      IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : WAIT;
      WAIT:    if (wait_cnt == wait_tgt) state_nxt = CAPTURE;
      CAPTURE: if (row_cnt == m_lat - 16'd1) state_nxt = DRAIN;
      DRAIN:   if (!out_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lat    <= '0;
      l_lat    <= '0;
      wait_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && num_vec != '0) begin
            m_lat    <= num_vec;
            l_lat    <= lat;
            wait_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        WAIT:    wait_cnt <= wait_cnt + 16'd1;
        CAPTURE: row_cnt  <= row_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                overflow <= 1'b0;
    else if (state == IDLE && start)        overflow <= 1'b0;
    else if (push && full && !pop)          overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: drives the skewed bottom-row schedule and
// scoreboards every popped vector against the expected row pattern.
module tb_sa_result_drain;

  localparam int WS    = 8;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;
  localparam int IW    = 2 * WS;
  localparam int VW    = COLS * IW;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [15:0]   num_vec;
  logic [7:0]    lat;
  logic [VW-1:0] res_in;
  logic          busy, done, out_valid, overflow;
  logic [VW-1:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  int edge_n = 0;
  int g_e0 = 0, g_m = 0, g_l = 0;
  bit g_on = 1'b0;

  int rx_idx = 0, done_cnt = 0, done_edge = 0, last_pop_edge = 0;
  logic [VW-1:0] first_rx, last_rx;

  typedef struct {
    int            m;
    int            l;
    logic [VW-1:0] first;
    logic [VW-1:0] last;
  } job_t;

  job_t jobs [4];

  sa_result_drain #(.WORD_SIZE(WS), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .lat(lat),
    .res_in(res_in), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [VW-1:0] row_word(input int r);
    logic [VW-1:0] w;
    w = '0;
    for (int c = 0; c < COLS; c++) w[c*IW +: IW] = {r[7:0], c[7:0]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Column c of row r is presented for edge E0+L+r+c; anything else is filler.
  always @(negedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      int r;
      r = edge_n + 1 - g_e0 - g_l - c;
      if (g_on && r >= 0 && r < g_m) res_in[c*IW +: IW] = {r[7:0], c[7:0]};
      else                           res_in[c*IW +: IW] = 16'hEE00 | 16'(c);
    end
  end

  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      chk("pop_data", out_data, row_word(rx_idx));
      if (rx_idx == 0) first_rx = out_data;
      last_rx = out_data;
      rx_idx++;
      last_pop_edge = edge_n + 1;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_n;
    end
  end

  task automatic start_job(input int m, input int l, input bit gen);
    @(negedge clk);
    start   = 1'b1;
    num_vec = 16'(m);
    lat     = 8'(l);
    if (gen) begin
      g_e0 = edge_n + 1; g_m = m; g_l = l; g_on = 1'b1;
      rx_idx = 0; done_cnt = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    chk(name, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    jobs[0] = '{2, 3, 64'h0003_0002_0001_0000, 64'h0103_0102_0101_0100};
    jobs[1] = '{1, 1, 64'h0003_0002_0001_0000, 64'h0003_0002_0001_0000};
    jobs[2] = '{5, 7, 64'h0003_0002_0001_0000, 64'h0403_0402_0401_0400};
    jobs[3] = '{8, 2, 64'h0003_0002_0001_0000, 64'h0703_0702_0701_0700};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; num_vec = '0; lat = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven jobs with an always-ready consumer
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      start_job(jobs[j].m, jobs[j].l, 1'b1);
      wait_done(300, "job_done");
      chk("job_rx_count",  64'(rx_idx),                     64'(jobs[j].m));
      chk("job_first",     first_rx,                        jobs[j].first);
      chk("job_last",      last_rx,                         jobs[j].last);
      chk("job_done_dly",  64'(done_edge - last_pop_edge),  64'd1);
      chk("job_overflow",  64'(overflow),                   64'd0);
      @(negedge clk); #2;
      chk("job_idle_busy", 64'(busy),      64'd0);
      chk("job_idle_done", 64'(done),      64'd0);
      chk("job_idle_vld",  64'(out_valid), 64'd0);
    end

    // Overflow: nine rows into eight entries with a stalled consumer
    out_ready = 1'b0;
    start_job(9, 2, 1'b1);
    e0 = g_e0;
    wait_edge(e0 + 2 + COLS - 1 + 8 + 2);
    out_ready = 1'b1;
    #2;
    chk("ovf_flag",      64'(overflow),  64'd1);
    chk("ovf_valid",     64'(out_valid), 64'd1);
    chk("ovf_busy",      64'(busy),      64'd1);
    chk("ovf_head",      out_data,       64'h0003_0002_0001_0000);
    wait_done(300, "ovf_done");
    chk("ovf_rx_count",  64'(rx_idx),    64'd8);
    chk("ovf_last",      last_rx,        64'h0703_0702_0701_0700);
    chk("ovf_sticky",    64'(overflow),  64'd1);

    // Start during CAPTURE is ignored; the accepted start clears overflow
    out_ready = 1'b1;
    start_job(4, 2, 1'b1);
    e0 = g_e0;
    chk("ign_ovf_clear", 64'(overflow), 64'd0);
    wait_edge(e0 + 2 + COLS - 1 + 1);
    start_job(7, 5, 1'b0);
    wait_done(300, "ign_done");
    chk("ign_rx_count",  64'(rx_idx),   64'd4);
    chk("ign_last",      last_rx,       64'h0303_0302_0301_0300);
    chk("ign_overflow",  64'(overflow), 64'd0);
    repeat (12) @(negedge clk);
    #2;
    chk("ign_done_cnt",  64'(done_cnt), 64'd1);
    chk("ign_busy",      64'(busy),     64'd0);

    // Empty job: done in the cycle right after the start edge
    start_job(0, 1, 1'b1);
    #2;
    chk("m0_done",   64'(done),      64'd1);
    chk("m0_busy",   64'(busy),      64'd1);
    chk("m0_valid",  64'(out_valid), 64'd0);
    @(negedge clk); #2;
    chk("m0_done_clr", 64'(done),      64'd0);
    chk("m0_busy_clr", 64'(busy),      64'd0);
    chk("m0_valid2",   64'(out_valid), 64'd0);
    chk("m0_rx",       64'(rx_idx),    64'd0);

    // Reset after two of five pushes, then a fresh job
    out_ready = 1'b0;
    start_job(5, 2, 1'b1);
    e0 = g_e0;
    wait_edge(e0 + 2 + COLS - 1 + 1);
    #1;
    chk("mid_valid_pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid",  64'(out_valid), 64'd0);
    chk("mid_busy",   64'(busy),      64'd0);
    chk("mid_data",   out_data,       64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    start_job(3, 4, 1'b1);
    wait_done(300, "post_rst_done");
    chk("post_rst_rx",   64'(rx_idx), 64'd3);
    chk("post_rst_last", last_rx,     64'h0203_0202_0201_0200);

    // Full FIFO with push and pop on the same edge
    out_ready = 1'b0;
    start_job(9, 1, 1'b1);
    e0 = g_e0;
    wait_edge(e0 + 1 + COLS - 1 + 7);
    out_ready = 1'b1;
    #2;
    chk("full_valid",    64'(out_valid), 64'd1);
    chk("full_ovf_pre",  64'(overflow),  64'd0);
    wait_done(300, "full_done");
    chk("full_rx_count", 64'(rx_idx),    64'd9);
    chk("full_last",     last_rx,        64'h0803_0802_0801_0800);
    chk("full_overflow", 64'(overflow),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
